counter_cmd_generator: RTL and testbench
========================================

Name: counter_cmd_generator

Overview:
- Initiator side of the counter control interface: turns raw pushbutton inputs into single-cycle command strobes for the modulo counter datapath.
- Sits between board keys and the counter.
- Synchronizes, debounces and prioritizes keys; emits one command per press, with optional hold-to-repeat.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required before a key's debounced state changes (>=2).
- REPEAT_DELAY, 24'd5000000: cycles a key must stay held after its first command before repeating starts (>=1).
- REPEAT_PERIOD, 24'd2500000: cycles between repeated commands while held (>=1).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Keys  input  4  raw active-high keys, asynchronous to Clock: [0]=add one, [1]=add two, [2]=subtract one, [3]=clear.
- Cmd  output  2  command code, valid only when CmdValid=1: 0=clear, 1=add one, 2=add two, 3=subtract one.
- CmdValid  output  1  one-cycle strobe; the counter acts on Cmd only in this cycle.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): all sync/debounce flops to 0 (released), FSM=IDLE, Cmd=2'h0, CmdValid=0, Busy=0, all timers 0.
- Synchronizer: 2-flop per key.
- Debounce: a per-key counter resets whenever the synchronized value equals the debounced value. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced value flips and the counter clears.
- Latency, raw edge to debounced: 2 + DEBOUNCE_CYCLES cycles, exact.
- Glitch handling: a glitch shorter than DEBOUNCE_CYCLES never changes the debounced state.
- Priority among simultaneously pressed debounced keys: clear > subtract one > add two > add one.
- FSM states:
  - IDLE: when any debounced key is pressed, latch the highest-priority key into SelKey and go to FIRE.
  - FIRE: CmdValid=1 and Cmd=code(SelKey) for exactly 1 cycle. Then go to HOLD, or to WAIT_REL if SelKey=clear or the repeat feature is absent.
  - HOLD: count REPEAT_DELAY cycles. If SelKey releases, go to WAIT_REL. At terminal count, go to FIRE_R.
  - FIRE_R: one-cycle strobe with the same code, then REPEAT.
  - REPEAT: count REPEAT_PERIOD cycles, then FIRE_R. If SelKey releases, go to WAIT_REL.
  - WAIT_REL: stay until all four debounced keys are released, then IDLE.
- Command latency: CmdValid rises exactly 1 cycle after the debounced press is registered.
- Other keys pressed while Busy are ignored. No new command issues until all keys release (no rollover).
- CmdValid is registered and never high for 2 consecutive cycles.
- Timers saturate; they never wrap.
- Reset mid-strobe: CmdValid drops immediately (async).

Optional Feature:
- Macro CMD_AUTOREPEAT_EN.
- Defined: the HOLD/FIRE_R/REPEAT path is compiled in as described above. Clear never repeats.
- Undefined: the HOLD, FIRE_R and REPEAT states and their timers are not built. FIRE always goes to WAIT_REL, giving exactly one command per press.

Decomposition:
- Package counter_cmd_pkg holds:
  - typedef enum logic [1:0] cmd_t {CMD_CLEAR, CMD_ADD1, CMD_ADD2, CMD_SUB1}
  - FSM state enum
  - key index constants KEY_ADD1..KEY_CLEAR
- Sub-module key_debouncer: 2-flop synchronizer plus debounce counter for one key, parameter DEBOUNCE_CYCLES, instantiated 4 times.
- Priority encoder and FSM stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4):
- Reset asserted mid-run, asynchronously -> CmdValid, Busy and Cmd go to 0 in the same cycle, with no clock edge required.
- Keys[0] held high 20 cycles, macro undefined -> exactly one CmdValid, Cmd=1, high 1 cycle, arriving 2+4+1 cycles after the first sampled high. No further strobes until release, Busy=1 until all keys are released.
- Keys[1] pulses high for 2 cycles (glitch) -> no CmdValid and Busy stays 0.
- Keys[0] and Keys[2] rise on the same cycle -> a single strobe with Cmd=3. Keys[0] released while Keys[2] is still held -> no further commands.
- Macro defined, Keys[2] held 30 cycles -> strobes at first press, +9 cycles (HOLD 8 + FIRE_R), then every 5 cycles. All strobes have Cmd=3 and each is 1 cycle wide.
- Macro defined, Keys[3] held 30 cycles -> exactly one strobe with Cmd=0 and no repeats.

Source files
------------

// File: rtl/counter_cmd_generator_pkg.sv
// Shared types and constants for counter_cmd_generator.
//   cmd_t     : command code presented on Cmd
//   state_t   : command FSM states
//   KEY_*     : bit index of each key within Keys
//   key_to_cmd: maps a key index to its command code
package counter_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_ADD1  = 2'd1,
    CMD_ADD2  = 2'd2,
    CMD_SUB1  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FIRE     = 3'd1,
    ST_HOLD     = 3'd2,
    ST_FIRE_R   = 3'd3,
    ST_REPEAT   = 3'd4,
    ST_WAIT_REL = 3'd5
  } state_t;

  localparam logic [1:0] KEY_ADD1  = 2'd0;
  localparam logic [1:0] KEY_ADD2  = 2'd1;
  localparam logic [1:0] KEY_SUB1  = 2'd2;
  localparam logic [1:0] KEY_CLEAR = 2'd3;

  function automatic cmd_t key_to_cmd(input logic [1:0] key);
    cmd_t code;
    case (key)
      KEY_ADD1: code = CMD_ADD1;
      KEY_ADD2: code = CMD_ADD2;
      KEY_SUB1: code = CMD_SUB1;
      default:  code = CMD_CLEAR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/counter_cmd_generator_key_debouncer.sv
// key_debouncer: two-flop synchronizer followed by a stability counter for
// one raw key.
//   clock     : system clock
//   reset     : async active-high reset
//   raw_key   : raw key, asynchronous to clock
//   debounced : filtered key state
// The debounced state flips only after the synchronized value has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
  import counter_cmd_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_key,
  output logic debounced
);

  logic        sync_1;
  logic        sync_2;
  logic [15:0] stable_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= '0;
      debounced  <= 1'b0;
    end else begin
      sync_1 <= raw_key;
      sync_2 <= sync_1;
      if (sync_2 == debounced) begin
        stable_cnt <= '0;
      end else if (stable_cnt >= DEBOUNCE_CYCLES - 16'd1) begin
        debounced  <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/counter_cmd_generator.sv
// counter_cmd_generator: turns four raw pushbuttons into single-cycle
// command strobes for the modulo counter.
//   Clock    : system clock, rising edge
//   Reset    : async active-high reset
//   Keys     : raw keys [0]=add1 [1]=add2 [2]=sub1 [3]=clear
//   Cmd      : command code, meaningful while CmdValid is high
//   CmdValid : one-cycle command strobe
//   Busy     : FSM is not idle
// Build option: define CMD_AUTOREPEAT_EN to compile in hold-to-repeat
// (HOLD / FIRE_R / REPEAT states and the repeat timer).
module counter_cmd_generator
  import counter_cmd_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Keys,
  output logic [1:0] Cmd,
  output logic       CmdValid,
  output logic       Busy
);

  if (DEBOUNCE_CYCLES < 16'd2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY == 24'd0 || REPEAT_PERIOD == 24'd0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [3:0] db_keys;
  logic       any_key;
  logic [1:0] pri_key;
  logic [1:0] sel_key;
  state_t     state;
  state_t     state_nx;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock    (Clock),
      .reset    (Reset),
      .raw_key  (Keys[i]),
      .debounced(db_keys[i])
    );
  end

  assign any_key = |db_keys;

  always_comb begin
    pri_key = KEY_ADD1;
    if (db_keys[KEY_CLEAR])     pri_key = KEY_CLEAR;
    else if (db_keys[KEY_SUB1]) pri_key = KEY_SUB1;
    else if (db_keys[KEY_ADD2]) pri_key = KEY_ADD2;
  end

`ifdef CMD_AUTOREPEAT_EN
  logic        sel_held;
  logic [23:0] timer;

  assign sel_held = db_keys[sel_key];
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (any_key) state_nx = ST_FIRE;
`ifdef CMD_AUTOREPEAT_EN
      ST_FIRE:     state_nx = (sel_key == KEY_CLEAR) ? ST_WAIT_REL : ST_HOLD;
      ST_HOLD,
      ST_REPEAT: begin
        // Release wins over a coincident terminal count.
        if (!sel_held)          state_nx = ST_WAIT_REL;
        else if (timer == '0)   state_nx = ST_FIRE_R;
      end
      ST_FIRE_R:   state_nx = ST_REPEAT;
`else
      ST_FIRE:     state_nx = ST_WAIT_REL;
`endif
      ST_WAIT_REL: if (!any_key) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // sel_key resets to clear so that Cmd reads 0 straight out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      sel_key  <= KEY_CLEAR;
      CmdValid <= 1'b0;
    end else begin
      state    <= state_nx;
      CmdValid <= (state_nx == ST_FIRE) || (state_nx == ST_FIRE_R);
      if (state == ST_IDLE && any_key) sel_key <= pri_key;
    end
  end

`ifdef CMD_AUTOREPEAT_EN
  // Down-counter reloaded on entry to HOLD or REPEAT; parks at zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      timer <= '0;
    end else if (state_nx == ST_HOLD && state != ST_HOLD) begin
      timer <= REPEAT_DELAY - 24'd1;
    end else if (state_nx == ST_REPEAT && state != ST_REPEAT) begin
      timer <= REPEAT_PERIOD - 24'd1;
    end else if (timer != '0) begin
      timer <= timer - 24'd1;
    end
  end
`endif

  assign Cmd  = key_to_cmd(sel_key);
  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_counter_cmd_generator.sv
// Directed bench for counter_cmd_generator with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs change 1 ns after a rising edge
// and outputs are read at the same point, so cycle c counts rising edges
// since the inputs were last changed. A press becomes debounced at c=6 and
// its strobe appears at c=7.
module tb_counter_cmd_generator;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] Keys;
  logic [1:0] Cmd;
  logic       CmdValid;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  counter_cmd_generator #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd8),
    .REPEAT_PERIOD  (24'd4)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Keys    (Keys),
    .Cmd     (Cmd),
    .CmdValid(CmdValid),
    .Busy    (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Keys  = 4'b0000;
    repeat (3) tick();
    checks++; if (CmdValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", CmdValid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd got %0d want 0", Cmd); end
    Reset = 1'b0;
    repeat (3) tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_single_add1();
    int   strobes = 0;
    int   first   = -1;
    logic prev    = 1'b0;
`ifdef CMD_AUTOREPEAT_EN
    int   exp_strobes = 2;
`else
    int   exp_strobes = 1;
`endif
    Keys = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (CmdValid === 1'b1) begin
        strobes++;
        if (first < 0) first = c;
        checks++; if (Cmd !== 2'd1) begin errors++; $display("FAIL add1_cmd got %0d want 1", Cmd); end
        checks++; if (prev === 1'b1) begin errors++; $display("FAIL add1_width got 2 cycles want 1 at c=%0d", c); end
      end
      if (c == 6) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add1_busy_early got %b want 0", Busy); end
      end
      if (c == 7 || c == 20) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL add1_busy_held c=%0d got %b want 1", c, Busy); end
      end
      prev = CmdValid;
    end
    checks++; if (first != 7) begin errors++; $display("FAIL add1_latency got %0d want 7", first); end
    checks++; if (strobes != exp_strobes) begin errors++; $display("FAIL add1_count got %0d want %0d", strobes, exp_strobes); end
    Keys = 4'b0000;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef CMD_AUTOREPEAT_EN
      if (c == 12) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add1_release got busy %b want 0", Busy); end
      end
`else
      if (c == 6) begin
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL add1_busy_release_early got %b want 1", Busy); end
      end
      if (c == 7) begin
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add1_release got busy %b want 0", Busy); end
      end
      if (CmdValid === 1'b1) begin
        checks++; errors++; $display("FAIL add1_release_strobe got 1 want 0 at c=%0d", c);
      end
`endif
    end
  endtask

  task automatic test_glitch();
    for (int len = 2; len <= 3; len++) begin
      int seen_valid = 0;
      int seen_busy  = 0;
      Keys = 4'b0010;
      repeat (len) tick();
      Keys = 4'b0000;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (CmdValid !== 1'b0) seen_valid++;
        if (Busy !== 1'b0) seen_busy++;
      end
      checks++; if (seen_valid != 0) begin errors++; $display("FAIL glitch%0d_valid got %0d strobes want 0", len, seen_valid); end
      checks++; if (seen_busy != 0) begin errors++; $display("FAIL glitch%0d_busy got %0d busy cycles want 0", len, seen_busy); end
    end
  endtask

  task automatic test_simultaneous();
    int strobes = 0;
    int first   = -1;
`ifdef CMD_AUTOREPEAT_EN
    int exp_strobes = 3;
`else
    int exp_strobes = 1;
`endif
    Keys = 4'b0101;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 10) Keys = 4'b0100;
      if (CmdValid === 1'b1) begin
        strobes++;
        if (first < 0) first = c;
        checks++; if (Cmd !== 2'd3) begin errors++; $display("FAIL simul_cmd got %0d want 3", Cmd); end
      end
    end
    checks++; if (first != 7) begin errors++; $display("FAIL simul_latency got %0d want 7", first); end
    checks++; if (strobes != exp_strobes) begin errors++; $display("FAIL simul_count got %0d want %0d", strobes, exp_strobes); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL simul_busy_held got %b want 1", Busy); end
    Keys = 4'b0000;
    repeat (15) tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL simul_release got busy %b want 0", Busy); end
  endtask

  task automatic test_autorepeat();
    int   at[8];
    int   strobes = 0;
    logic prev    = 1'b0;
`ifdef CMD_AUTOREPEAT_EN
    int   exp_at[4] = '{7, 16, 21, 26};
    int   exp_strobes = 4;
`else
    int   exp_at[4] = '{7, 0, 0, 0};
    int   exp_strobes = 1;
`endif
    Keys = 4'b0100;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (CmdValid === 1'b1) begin
        if (strobes < 8) at[strobes] = c;
        strobes++;
        checks++; if (Cmd !== 2'd3) begin errors++; $display("FAIL repeat_cmd got %0d want 3", Cmd); end
        checks++; if (prev === 1'b1) begin errors++; $display("FAIL repeat_width got 2 cycles want 1 at c=%0d", c); end
      end
      prev = CmdValid;
    end
    checks++; if (strobes != exp_strobes) begin errors++; $display("FAIL repeat_count got %0d want %0d", strobes, exp_strobes); end
    for (int i = 0; i < exp_strobes && i < strobes; i++) begin
      checks++; if (at[i] != exp_at[i]) begin errors++; $display("FAIL repeat_time[%0d] got %0d want %0d", i, at[i], exp_at[i]); end
    end
    Keys = 4'b0000;
    repeat (15) tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL repeat_release got busy %b want 0", Busy); end
  endtask

  task automatic test_clear_no_repeat();
    int strobes = 0;
    int first   = -1;
    Keys = 4'b1000;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (CmdValid === 1'b1) begin
        strobes++;
        if (first < 0) first = c;
        checks++; if (Cmd !== 2'd0) begin errors++; $display("FAIL clear_cmd got %0d want 0", Cmd); end
      end
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL clear_count got %0d want 1", strobes); end
    checks++; if (first != 7) begin errors++; $display("FAIL clear_latency got %0d want 7", first); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL clear_busy_held got %b want 1", Busy); end
    Keys = 4'b0000;
    repeat (12) tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL clear_release got busy %b want 0", Busy); end
  endtask

  task automatic test_async_reset();
    Keys = 4'b0001;
    repeat (7) tick();
    checks++; if (CmdValid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b want 1", CmdValid); end
    checks++; if (Cmd !== 2'd1) begin errors++; $display("FAIL areset_pre_cmd got %0d want 1", Cmd); end
    // Mid-cycle: no clock edge between asserting Reset and sampling.
    #2 Reset = 1'b1;
    #1;
    checks++; if (CmdValid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", CmdValid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", Busy); end
    checks++; if (Cmd !== 2'd0) begin errors++; $display("FAIL areset_cmd got %0d want 0", Cmd); end
    Keys = 4'b0000;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (10) tick();
    checks++; if (Busy !== 1'b0 || CmdValid !== 1'b0) begin
      errors++; $display("FAIL areset_after got busy %b valid %b want 0 0", Busy, CmdValid);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Keys  = 4'b0000;
    test_reset();
    test_single_add1();
    test_glitch();
    test_simultaneous();
    test_autorepeat();
    test_clear_no_repeat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
